// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, programmable wait, valid/ready response.
// Optional misaligned-access detection is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | counting down the access latency
  // RESP  | response held until resp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [3:0]      count;
  logic            lat_write;
  logic [AW-1:0]   lat_index;
  logic [31:0]     lat_data;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            mem_op;
  logic            op_write;
  logic [AW-1:0]   op_index;
  logic [31:0]     op_data;
  logic            misaligned;
  logic            addr_unused;

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign addr_unused = ^{req_address[31:AW+2], req_address[1:0]};

  // With zero latency the operation happens on the acceptance edge, so use the live request.
  assign op_write = (state == IDLE) ? req_write                : lat_write;
  assign op_index = (state == IDLE) ? req_address[AW+1:2]      : lat_index;
  assign op_data  = (state == IDLE) ? req_write_data           : lat_data;

  always_comb begin
    state_next = state;
    mem_op     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_next = RESP;
            mem_op     = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (count == 4'd1) begin
          state_next = RESP;
          mem_op     = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state          <= IDLE;
      count          <= 4'd0;
      lat_write      <= 1'b0;
      lat_index      <= '0;
      lat_data       <= 32'd0;
      resp_read_data <= 32'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        lat_write <= req_write;
        lat_index <= req_address[AW+1:2];
        lat_data  <= req_write_data;
        count     <= 4'(LATENCY);
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (mem_op) begin
        if (op_write && !misaligned) mem[op_index] <= op_data;
        resp_read_data <= (op_write || misaligned) ? 32'd0 : mem[op_index];
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] lat_offset;

  assign misaligned = ((state == IDLE) ? req_address[1:0] : lat_offset) != 2'd0;

  always_ff @(posedge clock) begin
    if (clear) begin
      lat_offset <= 2'd0;
      resp_error <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) lat_offset <= req_address[1:0];
      if (mem_op) resp_error <= misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance against a word-array model.
module tb_dmem_responder;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear, req_valid, req_write, resp_ready, sel;
  logic [31:0] req_address, req_write_data;

  logic        a_req_ready, a_resp_valid, a_err;
  logic [31:0] a_rdata;
  logic        b_req_ready, b_resp_valid, b_err;
  logic [31:0] b_rdata;

  logic        req_ready_o, resp_valid_o, err_o;
  logic [31:0] rdata_o;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .clock(clock), .clear(clear),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
    .resp_read_data(a_rdata), .resp_error(a_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
    .clock(clock), .clear(clear),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
    .resp_read_data(b_rdata), .resp_error(b_err)
  );

  assign req_ready_o  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid_o = sel ? b_resp_valid : a_resp_valid;
  assign rdata_o      = sel ? b_rdata      : a_rdata;
  assign err_o        = sel ? b_err        : a_err;

  logic [31:0] model [2][256];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd256);
  endfunction

  task automatic zero_model();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 256; w++) model[s][w] = 32'd0;
  endtask

  task automatic check_reset(input bit s);
    sel = s;
    #0;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
  endtask

  // One complete transaction; hold = number of cycles resp_ready stays low once the response is up.
  task automatic txn(input bit s, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input int hold);
    int lat, n, w;
    bit err;
    logic [31:0] exp;
    sel = s;
    lat = s ? 0 : 2;
    w   = word_of(addr);
    err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    err = (addr[1:0] != 2'd0);
`endif
    exp = (wr || err) ? 32'd0 : model[s][w];
    if (wr && !err) model[s][w] = data;
    #0;
    chk("idle_ready", req_ready_o, 1);
    req_valid = 1'b1; req_write = wr; req_address = addr; req_write_data = data;
    resp_ready = (hold == 0);
    step();
    chk("ready_drop", req_ready_o, 0);
    n = 0;
    while (resp_valid_o !== 1'b1 && n < 20) begin
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
      req_address = $urandom; req_write_data = $urandom;
      step();
      n++;
    end
    req_valid = 1'b0;
    chk("latency", n, lat);
    chk("rdata", rdata_o, exp);
    chk("rerr", err_o, {31'd0, err});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
      req_address = $urandom; req_write_data = $urandom;
      step();
      chk("hold_valid", resp_valid_o, 1);
      chk("hold_data", rdata_o, exp);
      chk("hold_ready", req_ready_o, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("consumed", resp_valid_o, 0);
    chk("back_idle", req_ready_o, 1);
    chk("data_retained", rdata_o, exp);
  endtask

  initial begin
    clear = 1'b1; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0; sel = 1'b0;
    req_address = 32'd0; req_write_data = 32'd0;
    zero_model();
    step(); step();
    clear = 1'b0;
    check_reset(0);
    check_reset(1);

    txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    txn(0, 0, 32'h0000_0010, 32'd0, 0);
    chk("plan_load", rdata_o, 32'hDEAD_BEEF);

    txn(1, 0, 32'h0000_0004, 32'd0, 0);
    txn(1, 0, 32'h0000_0008, 32'd0, 0);

    txn(0, 0, 32'h0000_0010, 32'd0, 5);
    chk("bp_data", rdata_o, 32'hDEAD_BEEF);

    txn(0, 1, 32'h0000_0400, 32'h1234_5678, 0);
    txn(0, 0, 32'h0000_0000, 32'd0, 0);
    chk("wrap_load", rdata_o, 32'h1234_5678);

    // Clear while a store sits in WAIT: it must never commit or respond.
    sel = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h20; req_write_data = 32'hCAFE_F00D;
    step();
    req_valid = 1'b0;
    chk("mid_wait", req_ready_o, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    zero_model();
    for (int i = 0; i < 4; i++) begin
      chk("no_resp_after_clear", resp_valid_o, 0);
      step();
    end
    check_reset(0);
    txn(0, 0, 32'h0000_0020, 32'd0, 0);
    chk("dropped_store", rdata_o, 32'd0);

    // A request presented together with clear is not taken.
    sel = 1'b0;
    clear = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_address = 32'h30; req_write_data = 32'h5A5A_5A5A;
    step();
    clear = 1'b0; req_valid = 1'b0;
    zero_model();
    chk("clear_vs_req", req_ready_o, 1);
    step();
    chk("clear_vs_req_nores", resp_valid_o, 0);
    txn(0, 0, 32'h0000_0030, 32'd0, 0);

`ifdef DMEM_ALIGN_CHECK_EN
    txn(0, 1, 32'h0000_0020, 32'hA5A5_0F0F, 0);
    txn(0, 1, 32'h0000_0022, 32'h1111_1111, 0);
    chk("mis_err", err_o, 1);
    txn(0, 0, 32'h0000_0020, 32'd0, 0);
    chk("mis_unchanged", rdata_o, 32'hA5A5_0F0F);
    chk("aligned_err", err_o, 0);
`endif

    for (int t = 0; t < 60; t++) begin
      logic [31:0] addr;
      addr = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
          int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the datapath's load/store port. It is the memory end of a request/response handshake that replaces the zero-latency combinational DataMemory.
- Accepts one word read or write at a time and completes it after a programmable number of wait cycles. Returns read data, or a write acknowledge, through a valid/ready response channel.
- Sits between the ALU-result/store-data path and the register-file write-back mux. The multi-cycle datapath stalls on it.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 4..4096.
- LATENCY, 2: wait cycles between request acceptance and the memory operation; 0..15.

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_address  in  32  byte address
- req_write_data  in  32  store data
- resp_valid  out  1  response present
- resp_ready  in  1  datapath consumes response
- resp_read_data  out  32  load data; 0 for stores
- resp_error  out  1  misaligned access; constant 0 unless DMEM_ALIGN_CHECK_EN

Behaviour:
- One clock domain: clock. clear is synchronous and active-high, sampled on the rising edge of clock. It has priority over every other input.
- Reset state on the edge where clear=1:
  - state=IDLE, req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0, wait counter=0.
  - All DEPTH_WORDS memory words zeroed.
- Word index = req_address[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4. Bits [1:0] are ignored unless the feature is enabled.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE), decoded from state. resp_valid = (state==RESP).
  - IDLE: on an edge with req_valid=1, the request is accepted. req_write, the word index and req_write_data are latched. LATENCY==0 goes straight to RESP and performs the memory operation on that same edge. Otherwise go to WAIT with counter=LATENCY.
  - WAIT: counter decrements each edge. On the edge where counter==1, perform the memory operation and go to RESP. Request inputs are ignored in WAIT.
  - Memory operation:
    - Store: mem[index] <= latched data; resp_read_data <= 0.
    - Load: resp_read_data <= mem[index].
    - resp_error is updated on the same edge.
  - RESP: resp_valid=1. resp_read_data and resp_error are held stable until an edge with resp_ready=1, then go to IDLE. Request inputs are ignored in RESP.
- Timing: acceptance edge k → resp_valid first high after edge k+LATENCY. No new request is accepted on the response-consume edge. Minimum period is LATENCY+2 cycles per transaction.
- resp_read_data and resp_error retain their last values in IDLE and WAIT.
- A load after a store to the same word returns the stored value. The store commits before RESP of the store.
- Reset mid-operation: a pending transaction in WAIT or RESP is dropped. A store that has not yet committed is never written; the array is zeroed anyway.
- Simultaneous clear and req_valid: the request is not accepted.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Latch req_address[1:0]. If nonzero at the memory-operation edge, no memory write occurs.
  - resp_read_data <= 0 and resp_error <= 1 on that edge.
  - Aligned accesses set resp_error <= 0 on that edge.
- Undefined: bits [1:0] are ignored, resp_error is tied 0, and no extra flops are generated.

Test Plan:
- LATENCY=2, after clear: store 0xDEADBEEF to 0x0000_0010, resp_ready=1.
  - Required: req_ready drops the cycle after acceptance; resp_valid high exactly 2 edges after acceptance; resp_read_data=0.
  - Then load 0x10 → resp_read_data=0xDEADBEEF.
- LATENCY=0: load 0x04 right after clear → resp_valid high on the cycle after acceptance with resp_read_data=0. Next request is accepted 2 edges after the previous acceptance.
- Backpressure: hold resp_ready=0 for 5 cycles on a load of 0xDEADBEEF.
  - Required: resp_valid and data stay stable; req_valid pulses are ignored (req_ready=0).
  - Release → IDLE on the next edge.
- Wrap-around, DEPTH_WORDS=256: store 0x12345678 to 0x0000_0400, then load 0x0000_0000 → 0x12345678.
- Clear during WAIT of a store 0xCAFEF00D to 0x20 → resp_valid never asserts. A later load of 0x20 returns 0.
- With DMEM_ALIGN_CHECK_EN: store 0x11111111 to 0x22 → resp_error=1 and memory unchanged. Then load 0x20 → its prior value with resp_error=0.
